seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter DIV_W, default 16, prescaler width; each digit is displayed for 2^DIV_W clocks.
REQ-003 SHALL have parameter DEAD, default 2, anti-ghost blanking clocks at each digit start; legal range 0 <= DEAD < 2^DIV_W.
REQ-004 SHALL have parameter BLINK_W, default 5; the blink phase toggles every 2^BLINK_W frames.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port mode, input, 1 bit: 0 selects hex-decode mode, 1 selects graphic (raw segment) mode.
REQ-008 SHALL have port hex_data, input, 4*N_DIGITS bits: nibble i is digit i.
REQ-009 SHALL have port gfx_data, input, 8*N_DIGITS bits: byte i is the raw segments of digit i, active-high {dp,g,f,e,d,c,b,a}.
REQ-010 SHALL have port point, input, N_DIGITS bits: decimal point per digit in hex mode.
REQ-011 SHALL have port blank, input, N_DIGITS bits: 1 forces digit i dark.
REQ-012 SHALL have port blink, input, N_DIGITS bits: 1 makes digit i blink.
REQ-013 SHALL have port load, input, 1 bit: one-clock strobe that captures mode, hex_data, gfx_data, point, blank and blink.
REQ-014 SHALL have port seg_n, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-015 SHALL have port an_n, output, N_DIGITS bits: active-low digit enables.
REQ-016 SHALL have port scan_idx, output, clog2(N_DIGITS) bits: the current digit index.
REQ-017 SHALL have port frame_tick, output, 1 bit: one-clock pulse when scan_idx wraps from N_DIGITS-1 to 0.

Function
REQ-018 SHALL run the DIV_W-bit prescaler free from 0 to 2^DIV_W-1 and wrap; on wrap, scan_idx SHALL increment modulo N_DIGITS.
REQ-019 SHALL raise frame_tick for exactly the clock in which scan_idx changes from N_DIGITS-1 to 0.
REQ-020 SHALL capture load into a pending register set and set pending_valid.
REQ-021 SHALL copy pending to the active set at frame_tick and clear pending_valid; a load in the frame_tick clock goes directly to active (no tearing, newest data wins).
REQ-022 SHALL count frame_ticks with a BLINK_W-bit counter and toggle blink_phase on its wrap.
REQ-023 SHALL use hex mode segments = decode(nibble) with dp = point[i]; graphic mode SHALL use gfx byte i unchanged.
REQ-024 SHALL use decode 0->a..f, 1->b,c, 2->a,b,d,e,g, 3->a,b,c,d,g, 4->b,c,f,g, 5->a,c,d,f,g, 6->a,c,d,e,f,g, 7->a,b,c, 8->all, 9->a,b,c,d,f,g, A->a,b,c,e,f,g, b->c,d,e,f,g, C->a,d,e,f, d->b,c,d,e,g, E->a,d,e,f,g, F->a,e,f,g.
REQ-025 SHALL drive an_n all ones and seg_n 8'hFF when prescaler < DEAD, blank[i] = 1, or (blink[i] and blink_phase) holds for active digit i.
REQ-026 SHALL otherwise drive an_n with only bit scan_idx low and seg_n as the inverted segments.
REQ-027 SHALL register seg_n and an_n, lagging the prescaler/scan_idx state by exactly 1 clock; scan_idx and frame_tick SHALL be registered state.

Reset
REQ-028 SHALL, while rst_n = 0, hold prescaler = 0, scan_idx = 0, frame_tick = 0, blink counter and phase = 0, active and pending sets = 0, pending_valid = 0, seg_n = 8'hFF, an_n = all ones.
REQ-029 SHALL discard an in-flight pending load if reset asserts mid-frame; first digit output SHALL follow deassertion by DEAD+1 clocks.

Structure
REQ-030 SHALL place the segment bit-position constants and the hex-to-segment table function in shared package seg_pkg.
REQ-031 SHALL implement the decode as combinational sub-module seg_hex_decode (4-bit in, 7-bit active-high out).

Verification (N_DIGITS=4, DIV_W=2, DEAD=1, BLINK_W=1)
REQ-032 SHALL cover: reset release, load hex_data=16'h3210, mode=0, point=0 -> after the first frame boundary, digits 0..3 show seg_n C0,F9,A4,B0, and an_n is 1111 for 1 clock at each digit start.
REQ-033 SHALL cover: free run -> frame_tick pulses once every 16 clocks, and scan_idx sequence is 0,1,2,3,0.
REQ-034 SHALL cover: mode=1, gfx_data byte2=8'h81, load mid-frame -> old data until frame_tick, then digit 2 seg_n=8'h7E.
REQ-035 SHALL cover: blink=4'b0010 -> digit 1 dark on alternating 2-frame periods, others unaffected; blank=4'b1000 -> digit 3 always dark.
REQ-036 SHALL cover: load coincident with frame_tick -> new data visible in the very next frame.
REQ-037 SHALL cover: rst_n low mid-digit -> seg_n=8'hFF, an_n=4'hF immediately (asynchronous); pending discarded after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared segment-bit positions and the hex glyph table for the display scanner.
// Segment vectors are active-high {dp,g,f,e,d,c,b,a}; SEG_DARK is the all-off active-low pattern.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_DARK = 8'hFF;

    // Returns active-high {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-high 7-segment glyph {g,f,e,d,c,b,a}.
// Purely combinational, zero latency; no flow control.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner with frame-synchronous double-buffered display data.
// seg_n/an_n lag the scan state by one clock; load is never stalled (newest load wins).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int DIV_W    = 16,
    parameter int DEAD     = 2,
    parameter int BLINK_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic [4*N_DIGITS-1:0]       hex_data,
    input  logic [8*N_DIGITS-1:0]       gfx_data,
    input  logic [N_DIGITS-1:0]         point,
    input  logic [N_DIGITS-1:0]         blank,
    input  logic [N_DIGITS-1:0]         blink,
    input  logic                        load,
    output logic [7:0]                  seg_n,
    output logic [N_DIGITS-1:0]         an_n,
    output logic [$clog2(N_DIGITS)-1:0] scan_idx,
    output logic                        frame_tick
);

    localparam int                IDX_W    = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0]  DEAD_CNT = DIV_W'(DEAD);

    typedef struct packed {
        logic                  mode;
        logic [4*N_DIGITS-1:0] hex;
        logic [8*N_DIGITS-1:0] gfx;
        logic [N_DIGITS-1:0]   point;
        logic [N_DIGITS-1:0]   blank;
        logic [N_DIGITS-1:0]   blink;
    } disp_t;

    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic                frame_tick_q;
    logic [BLINK_W-1:0]  blink_cnt_q;
    logic                blink_phase_q;
    disp_t               act_q, pend_q, load_dat;
    logic                pend_vld_q;
    logic [7:0]          seg_n_q, seg_n_d;
    logic [N_DIGITS-1:0] an_n_q, an_n_d;
    logic                digit_wrap, frame_wrap;
    int                  cur_i;
    logic [3:0]          cur_nib;
    logic [6:0]          hex_seg;
    logic [7:0]          cur_seg;
    logic                dark;

    assign load_dat   = {mode, hex_data, gfx_data, point, blank, blink};
    assign digit_wrap = (presc_q == '1);
    assign frame_wrap = digit_wrap && (scan_idx_q == LAST_IDX);
    assign presc_d    = presc_q + 1'b1;
    assign scan_idx_d = !digit_wrap              ? scan_idx_q :
                        (scan_idx_q == LAST_IDX) ? '0         : scan_idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            scan_idx_q    <= '0;
            frame_tick_q  <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            scan_idx_q   <= scan_idx_d;
            frame_tick_q <= frame_wrap;
            if (frame_wrap) begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
                if (blink_cnt_q == '1) begin
                    blink_phase_q <= ~blink_phase_q;
                end
            end
        end
    end

    // Active set only changes on the wrap edge, so a whole frame always shows one snapshot;
    // a load on that same edge bypasses pending so the newest data is what goes live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else if (frame_wrap) begin
            if (load) begin
                act_q <= load_dat;
            end else if (pend_vld_q) begin
                act_q <= pend_q;
            end
            pend_vld_q <= 1'b0;
        end else if (load) begin
            pend_q     <= load_dat;
            pend_vld_q <= 1'b1;
        end
    end

    assign cur_i   = int'(scan_idx_q);
    assign cur_nib = act_q.hex[4*cur_i +: 4];

    seg_hex_decode u_hex_decode (
        .nib_i (cur_nib),
        .seg_o (hex_seg)
    );

    always_comb begin
        seg_n_d = SEG_DARK;
        an_n_d  = '1;
        cur_seg = act_q.mode ? act_q.gfx[8*cur_i +: 8] : {act_q.point[cur_i], hex_seg};
        dark    = (presc_q < DEAD_CNT) || act_q.blank[cur_i] ||
                  (act_q.blink[cur_i] && blink_phase_q);
        if (!dark) begin
            seg_n_d = ~cur_seg;
            an_n_d  = ~(N_DIGITS'(1) << scan_idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n_q <= SEG_DARK;
            an_n_q  <= '1;
        end else begin
            seg_n_q <= seg_n_d;
            an_n_q  <= an_n_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign scan_idx   = scan_idx_q;
    assign frame_tick = frame_tick_q;

endmodule
